emu_iic_multi: RTL and testbench
================================

Name: emu_iic_multi

Overview:
- Parametrised I2C device emulator that replaces the single-switch/single-Si570 emulator.
- It presents the same register-style front-end: dev addr, reg num, read/write length strobes, status and RX data.
- It emulates NUM_DEVS byte-addressed register files. Each file has a per-device auto-increment pointer, serial per-byte timing and an NACK fault for unmatched addresses.
- Used in simulation and hardware-less builds in place of the AXI IIC path.

Parameters:
- NUM_DEVS, 4, number of emulated I2C devices (1..8).
- DEV_ADDRS, {7'h70,7'h55,7'h50,7'h20}, packed 7-bit addresses. Device i occupies bits [7i+6:7i], so device 0 is in the LSBs.
- REGS_PER_DEV, 256, registers per device. Power of 2, 2..65536.
- BYTE_CLKS, 10, clocks consumed per I2C byte (address byte and each data byte).
- CLKS_PER_USEC, 100, clock cycles per microsecond.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- idle  out  1  high in IDLE with no start strobe asserted (combinational)
- i_I2C_DEV_ADDR  in  7  target device address
- i_I2C_REG_NUM_LEN  in  2  register-number bytes: 0 = use stored pointer, 1 = REG_NUM[7:0], 2 or 3 = REG_NUM[15:0]
- i_I2C_REG_NUM  in  16  starting register
- i_I2C_READ_LEN  in  3  read byte count, 1..4
- i_I2C_READ_LEN_wstrobe  in  1  starts a read
- i_I2C_TX_DATA  in  32  write data; first byte sent = byte [LEN-1]
- i_I2C_WRITE_LEN  in  3  write byte count, 1..4
- i_I2C_WRITE_LEN_wstrobe  in  1  starts a write
- i_I2C_TLIMIT_USEC  in  32  transaction limit in µs; 0 = no limit
- o_MODULE_REV  out  32  constant 2
- o_I2C_STATUS  out  8  {5'b0, i2c_timeout, bus_fault, idle}
- o_I2C_RX_DATA  out  32  read result; first byte read lands in byte [LEN-1]
- o_I2C_TRANSACT_USEC  out  32  µs duration of last transaction

Behaviour:
- Reset (async):
  - State goes to INIT; idle=0.
  - i2c_timeout, bus_fault, RX data, TRANSACT_USEC and all per-device pointers are cleared to 0.
  - The µs counter is cleared.
- INIT:
  - Clears storage one byte per clock, NUM_DEVS*REGS_PER_DEV cycles, then enters IDLE.
  - Strobes during INIT are ignored.
- Storage is a single flat byte RAM, index = dev_idx*REGS_PER_DEV + reg. At most one byte is read or written per clock.
- IDLE:
  - A strobe with length 1..4 latches dev addr, reg num, len and TX data. It clears timeout, bus_fault and the µs counter, then enters ADDR.
  - If both strobes are valid in the same cycle, the write wins.
  - Length 0 or 5..7: the strobe is ignored and status is unchanged.
  - Strobes outside IDLE are ignored.
- ADDR:
  - Waits BYTE_CLKS cycles, then compares the address against DEV_ADDRS. On duplicate addresses the lowest index wins.
  - No match: set bus_fault, RX data = 32'hDEAD_BEEF, go to DONE.
  - Match: the start reg is the pointer (len 0) or REG_NUM masked to log2(REGS_PER_DEV) bits. Go to DATA.
- DATA (per byte, k = 0..LEN-1):
  - Wait BYTE_CLKS cycles, then access reg (start+k) mod REGS_PER_DEV.
  - Read: RX byte [LEN-1-k] <= mem. RX data is cleared to 0 at transaction start, so unused bytes read as 0.
  - Write: mem <= TX byte [LEN-1-k].
- Pointer: after the last byte, the device pointer = (start+LEN) mod REGS_PER_DEV. Wrap past the last reg returns to reg 0.
- DONE: o_I2C_TRANSACT_USEC <= elapsed µs, then go to IDLE.
- Timeout:
  - Applies in ADDR or DATA when limit≠0 and elapsed µs >= limit.
  - Abort to DONE, set i2c_timeout, RX data = 32'hDEAD_BEEF.
  - Bytes already written stay written; the pointer is not updated.
- Latency: total clocks = (1+LEN)*BYTE_CLKS + 2 from strobe to idle.

Test Plan:
- Reset, wait INIT, then read dev 0x55 reg 7 len 4 -> RX=0, bus_fault=0, idle returns after 5*BYTE_CLKS+2 clocks, TRANSACT_USEC=0 at 100 clk/µs with BYTE_CLKS=10.
- Write 0x55 reg 7 len 3 TX=0x00AABBCC, then read 0x55 reg 7 len 3 -> RX=0x00AABBCC. Read reg 8 len 1 -> RX=0x000000BB.
- Write 0x50 REG_NUM_LEN=1 reg 0xFE len 4 TX=0x11223344, then read reg 0xFF len 2 -> RX=0x00002233 (wrap). Read REG_NUM_LEN=0 len 1 -> RX=0x44 (pointer = 1 before the read, 2 after).
- Read dev 0x33 -> bus_fault=1, timeout=0, RX=0xDEADBEEF, status=0x03 once idle. A following valid read clears bus_fault.
- TLIMIT_USEC=1, BYTE_CLKS=100, write len 4 -> i2c_timeout=1, TRANSACT_USEC=1, RX=0xDEADBEEF.
- Edge cases:
  - Read strobe with len 0 -> ignored.
  - Read and write strobes together -> write performed.
  - Strobe while busy -> ignored.
  - Assert reset mid-DATA -> status 0, idle low through INIT, and a subsequent read returns 0.

Source files
------------

// File: rtl/emu_iic_multi.sv
// emu_iic_multi: register-style front end emulating NUM_DEVS byte-addressed I2C devices
// Ports: clk/reset (async, active-high); idle; i_I2C_* request fields and read/write
// strobes; o_MODULE_REV (=2); o_I2C_STATUS {5'b0,timeout,bus_fault,idle};
// o_I2C_RX_DATA read result; o_I2C_TRANSACT_USEC duration of the last transaction.
module emu_iic_multi #(
  parameter int NUM_DEVS = 4,
  parameter logic [7*NUM_DEVS-1:0] DEV_ADDRS = {7'h70, 7'h55, 7'h50, 7'h20},
  parameter int REGS_PER_DEV = 256,
  parameter int BYTE_CLKS = 10,
  parameter int CLKS_PER_USEC = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        idle,
  input  logic [6:0]  i_I2C_DEV_ADDR,
  input  logic [1:0]  i_I2C_REG_NUM_LEN,
  input  logic [15:0] i_I2C_REG_NUM,
  input  logic [2:0]  i_I2C_READ_LEN,
  input  logic        i_I2C_READ_LEN_wstrobe,
  input  logic [31:0] i_I2C_TX_DATA,
  input  logic [2:0]  i_I2C_WRITE_LEN,
  input  logic        i_I2C_WRITE_LEN_wstrobe,
  input  logic [31:0] i_I2C_TLIMIT_USEC,
  output logic [31:0] o_MODULE_REV,
  output logic [7:0]  o_I2C_STATUS,
  output logic [31:0] o_I2C_RX_DATA,
  output logic [31:0] o_I2C_TRANSACT_USEC
);
  localparam int AW = $clog2(REGS_PER_DEV);
  localparam int DW = NUM_DEVS > 1 ? $clog2(NUM_DEVS) : 1;
  localparam int TOTAL = NUM_DEVS * REGS_PER_DEV;
  localparam int IW = $clog2(TOTAL);
  localparam int CW = $clog2(BYTE_CLKS + 1);
  localparam int SW = $clog2(CLKS_PER_USEC + 1);
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
  typedef enum logic [2:0] {INIT, IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [TOTAL];
  logic [AW-1:0] ptr [NUM_DEVS];
  logic [IW-1:0] init_cnt, idx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sub;
  logic [31:0] usec, tx, rx, transact;
  logic [15:0] rn;
  logic [6:0] dev;
  logic [2:0] len;
  logic [1:0] k, sel;
  logic [DW-1:0] dev_idx, hit_idx;
  logic [AW-1:0] sreg, cur;
  logic use_ptr, is_wr, tmo, fault, hit;
  logic rd_ok, wr_ok, start, byte_end, last, tout, mem_we;
  logic [7:0] mem_wd, rd;

  assign rd_ok = i_I2C_READ_LEN_wstrobe && i_I2C_READ_LEN != 3'd0 && i_I2C_READ_LEN <= 3'd4;
  assign wr_ok = i_I2C_WRITE_LEN_wstrobe && i_I2C_WRITE_LEN != 3'd0 && i_I2C_WRITE_LEN <= 3'd4;
  assign start = state == IDLE && (rd_ok || wr_ok);
  assign byte_end = cnt == CW'(BYTE_CLKS - 1);
  assign last = k == 2'(len - 3'd1);
  assign tout = (state == ADDR || state == DATA) && i_I2C_TLIMIT_USEC != 32'd0 &&
                usec >= i_I2C_TLIMIT_USEC;
  assign cur = sreg + AW'(k);
  // byte k travels in byte lane LEN-1-k (first byte on the wire is the MSB lane)
  assign sel = len[1:0] - 2'd1 - k;
  assign idx = state == INIT ? init_cnt : IW'(32'(dev_idx) * REGS_PER_DEV + 32'(cur));
  assign mem_we = state == INIT || (state == DATA && byte_end && !tout && is_wr);
  assign mem_wd = state == INIT ? 8'h00 : tx[8*sel +: 8];
  assign rd = mem[idx];
  assign idle = state == IDLE && !start;
  assign o_MODULE_REV = 32'd2;
  assign o_I2C_STATUS = {5'b0, tmo, fault, idle};
  assign o_I2C_RX_DATA = rx;
  assign o_I2C_TRANSACT_USEC = transact;

  // scan from the top so the lowest matching index wins on duplicate addresses
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEVS - 1; i >= 0; i--)
      if (dev == DEV_ADDRS[7*i +: 7]) begin
        hit = 1'b1;
        hit_idx = DW'(i);
      end
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT: state_n = init_cnt == IW'(TOTAL - 1) ? IDLE : INIT;
      IDLE: state_n = start ? ADDR : IDLE;
      ADDR: state_n = tout ? DONE : !byte_end ? ADDR : hit ? DATA : DONE;
      DATA: state_n = tout || (byte_end && last) ? DONE : DATA;
      DONE: state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= INIT;
    else state <= state_n;

  always_ff @(posedge clk)
    if (mem_we) mem[idx] <= mem_wd;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      init_cnt <= '0;
      cnt <= '0;
      sub <= '0;
      usec <= '0;
      tx <= '0;
      rx <= '0;
      transact <= '0;
      rn <= '0;
      dev <= '0;
      len <= '0;
      k <= '0;
      dev_idx <= '0;
      sreg <= '0;
      use_ptr <= 1'b0;
      is_wr <= 1'b0;
      tmo <= 1'b0;
      fault <= 1'b0;
      for (int i = 0; i < NUM_DEVS; i++) ptr[i] <= '0;
    end else begin
      init_cnt <= state == INIT ? init_cnt + 1'b1 : '0;
      cnt <= (state == ADDR || state == DATA) && !byte_end ? cnt + 1'b1 : '0;
      if (start) begin
        sub <= '0;
        usec <= '0;
      end else if (sub == SW'(CLKS_PER_USEC - 1)) begin
        sub <= '0;
        usec <= usec + 32'd1;
      end else sub <= sub + 1'b1;
      if (start) begin
        is_wr <= wr_ok;
        len <= wr_ok ? i_I2C_WRITE_LEN : i_I2C_READ_LEN;
        dev <= i_I2C_DEV_ADDR;
        use_ptr <= i_I2C_REG_NUM_LEN == 2'd0;
        rn <= i_I2C_REG_NUM_LEN == 2'd1 ? {8'h00, i_I2C_REG_NUM[7:0]} : i_I2C_REG_NUM;
        tx <= i_I2C_TX_DATA;
        rx <= '0;
        k <= '0;
        tmo <= 1'b0;
        fault <= 1'b0;
      end
      if (state == ADDR) begin
        if (tout) begin
          tmo <= 1'b1;
          rx <= DEAD;
        end else if (byte_end && !hit) begin
          fault <= 1'b1;
          rx <= DEAD;
        end else if (byte_end) begin
          dev_idx <= hit_idx;
          sreg <= use_ptr ? ptr[hit_idx] : AW'(rn);
        end
      end
      if (state == DATA) begin
        if (tout) begin
          tmo <= 1'b1;
          rx <= DEAD;
        end else if (byte_end) begin
          k <= k + 1'b1;
          if (!is_wr) rx[8*sel +: 8] <= rd;
          if (last) ptr[dev_idx] <= sreg + AW'(len);
        end
      end
      if (state == DONE) transact <= usec;
    end
endmodule

// File: tb/tb_emu_iic_multi.sv
// tb_emu_iic_multi: table-driven scoreboard bench for emu_iic_multi
module tb_emu_iic_multi;
  typedef struct {
    bit rd;
    bit wr;
    logic [6:0] dev;
    logic [1:0] rnl;
    logic [15:0] rn;
    logic [2:0] len;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [7:0] st;
    int cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] dev = '0;
  logic [1:0] rnl = '0;
  logic [15:0] rn = '0;
  logic [2:0] rlen = '0, wlen = '0;
  logic [31:0] tx = '0, tlim = '0;
  logic rs = 1'b0, ws = 1'b0, rs2 = 1'b0, ws2 = 1'b0;
  logic idle1, idle2;
  logic [7:0] st1, st2;
  logic [31:0] rev1, rev2, rx1, rx2, us1, us2;
  int n_vec = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  emu_iic_multi dut1 (
    .clk(clk), .reset(reset), .idle(idle1),
    .i_I2C_DEV_ADDR(dev), .i_I2C_REG_NUM_LEN(rnl), .i_I2C_REG_NUM(rn),
    .i_I2C_READ_LEN(rlen), .i_I2C_READ_LEN_wstrobe(rs),
    .i_I2C_TX_DATA(tx), .i_I2C_WRITE_LEN(wlen), .i_I2C_WRITE_LEN_wstrobe(ws),
    .i_I2C_TLIMIT_USEC(tlim), .o_MODULE_REV(rev1), .o_I2C_STATUS(st1),
    .o_I2C_RX_DATA(rx1), .o_I2C_TRANSACT_USEC(us1)
  );

  emu_iic_multi #(.BYTE_CLKS(100)) dut2 (
    .clk(clk), .reset(reset), .idle(idle2),
    .i_I2C_DEV_ADDR(dev), .i_I2C_REG_NUM_LEN(rnl), .i_I2C_REG_NUM(rn),
    .i_I2C_READ_LEN(rlen), .i_I2C_READ_LEN_wstrobe(rs2),
    .i_I2C_TX_DATA(tx), .i_I2C_WRITE_LEN(wlen), .i_I2C_WRITE_LEN_wstrobe(ws2),
    .i_I2C_TLIMIT_USEC(tlim), .o_MODULE_REV(rev2), .o_I2C_STATUS(st2),
    .o_I2C_RX_DATA(rx2), .o_I2C_TRANSACT_USEC(us2)
  );

  function automatic vec_t mk(bit r, bit w, logic [6:0] d, logic [1:0] l, logic [15:0] n,
                              logic [2:0] ln, logic [31:0] t, logic [31:0] x, logic [7:0] s, int c);
    vec_t v;
    v.rd = r; v.wr = w; v.dev = d; v.rnl = l; v.rn = n; v.len = ln;
    v.tx = t; v.rx = x; v.st = s; v.cyc = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input bit second, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(posedge clk);
      #1;
      rs = 1'b0; ws = 1'b0; rs2 = 1'b0; ws2 = 1'b0;
      n++;
      ok = second ? idle2 : idle1;
    end
  endtask

  task automatic run(input vec_t v, input bit second, input string name);
    int n;
    bit ok;
    vec_t e;
    @(negedge clk);
    dev = v.dev; rnl = v.rnl; rn = v.rn; rlen = v.len; wlen = v.len; tx = v.tx;
    if (second) begin rs2 = v.rd; ws2 = v.wr; end
    else begin rs = v.rd; ws = v.wr; end
    sb.push_back(v);
    wait_idle(second, n, ok);
    e = sb.pop_front();
    chk({name, " done"}, 32'(ok), 32'd1);
    chk({name, " rx"}, second ? rx2 : rx1, e.rx);
    chk({name, " status"}, 32'(second ? st2 : st1), 32'(e.st));
    chk({name, " cycles"}, 32'(n), 32'(e.cyc));
  endtask

  initial begin
    int n;
    bit ok;
    tbl[0]  = mk(1, 0, 7'h55, 2, 16'h0007, 4, 32'h0, 32'h0, 8'h01, 52);
    tbl[1]  = mk(0, 1, 7'h55, 2, 16'h0007, 3, 32'h00AABBCC, 32'h0, 8'h01, 42);
    tbl[2]  = mk(1, 0, 7'h55, 2, 16'h0007, 3, 32'h0, 32'h00AABBCC, 8'h01, 42);
    tbl[3]  = mk(1, 0, 7'h55, 2, 16'h0008, 1, 32'h0, 32'h000000BB, 8'h01, 22);
    tbl[4]  = mk(0, 1, 7'h50, 1, 16'h12FE, 4, 32'h11223344, 32'h0, 8'h01, 52);
    tbl[5]  = mk(1, 0, 7'h50, 1, 16'h00FF, 2, 32'h0, 32'h00002233, 8'h01, 32);
    tbl[6]  = mk(1, 0, 7'h50, 0, 16'h0000, 1, 32'h0, 32'h00000044, 8'h01, 22);
    tbl[7]  = mk(1, 0, 7'h33, 2, 16'h0000, 1, 32'h0, 32'hDEADBEEF, 8'h03, 12);
    tbl[8]  = mk(1, 0, 7'h50, 0, 16'h0000, 1, 32'h0, 32'h00000000, 8'h01, 22);
    tbl[9]  = mk(0, 1, 7'h20, 2, 16'hFF05, 1, 32'h0000005A, 32'h0, 8'h01, 22);
    tbl[10] = mk(1, 0, 7'h20, 1, 16'h0005, 2, 32'h0, 32'h00005A00, 8'h01, 32);
    tbl[11] = mk(0, 1, 7'h70, 2, 16'h0007, 1, 32'h00000077, 32'h0, 8'h01, 22);
    tbl[12] = mk(1, 0, 7'h55, 2, 16'h0007, 1, 32'h0, 32'h000000AA, 8'h01, 22);
    tbl[13] = mk(1, 0, 7'h70, 2, 16'h0006, 2, 32'h0, 32'h00000077, 8'h01, 32);
    tbl[14] = mk(1, 1, 7'h55, 2, 16'h0020, 1, 32'h00000099, 32'h0, 8'h01, 22);
    tbl[15] = mk(1, 0, 7'h55, 2, 16'h0020, 1, 32'h0, 32'h00000099, 8'h01, 22);
    repeat (3) @(negedge clk);
    chk("reset status", 32'(st1), 32'h0);
    chk("reset rx", rx1, 32'h0);
    chk("reset usec", us1, 32'h0);
    chk("module rev", rev1, 32'd2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("init idle low", 32'(idle1), 32'd0);
    rs = 1'b1;
    wlen = 3'd1;
    rlen = 3'd1;
    wait_idle(0, n, ok);
    chk("init done", 32'(ok), 32'd1);
    chk("init done dut2", 32'(idle2), 32'd1);
    for (int i = 0; i < 16; i++) begin
      run(tbl[i], 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d usec", i), us1, 32'h0);
    end
    @(negedge clk);
    rlen = 3'd0;
    rs = 1'b1;
    @(posedge clk);
    #1;
    rs = 1'b0;
    chk("len0 ignored idle", 32'(idle1), 32'd1);
    chk("len0 ignored status", 32'(st1), 32'h01);
    @(negedge clk);
    wlen = 3'd5;
    ws = 1'b1;
    @(posedge clk);
    #1;
    ws = 1'b0;
    chk("len5 ignored idle", 32'(idle1), 32'd1);
    @(negedge clk);
    dev = 7'h55; rnl = 2'd2; rn = 16'h0007; rlen = 3'd1; rs = 1'b1;
    @(posedge clk);
    #1;
    rs = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    wlen = 3'd1; tx = 32'h000000EE; ws = 1'b1;
    @(posedge clk);
    #1;
    ws = 1'b0;
    wait_idle(0, n, ok);
    chk("busy cycles", 32'(7 + n), 32'd22);
    chk("busy rx", rx1, 32'h000000AA);
    run(mk(1, 0, 7'h55, 2, 16'h0007, 1, 32'h0, 32'h000000AA, 8'h01, 22), 0, "after busy");
    tlim = 32'd1;
    run(mk(0, 1, 7'h50, 2, 16'h0010, 4, 32'hCAFEF00D, 32'hDEADBEEF, 8'h05, 103), 1, "timeout");
    chk("timeout usec", us2, 32'd1);
    tlim = 32'd0;
    @(negedge clk);
    dev = 7'h55; rnl = 2'd2; rn = 16'h0007; wlen = 3'd4; tx = 32'h01020304; ws = 1'b1;
    @(posedge clk);
    #1;
    ws = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset status", 32'(st1), 32'h0);
    chk("midreset idle", 32'(idle1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("reinit idle low", 32'(idle1), 32'd0);
    wait_idle(0, n, ok);
    chk("reinit done", 32'(ok), 32'd1);
    run(mk(1, 0, 7'h55, 2, 16'h0007, 4, 32'h0, 32'h0, 8'h01, 52), 0, "after reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
